// File: rtl/apb_master_sched.sv
// apb_master_sched: round-robin scheduler sharing one APB master port.
// Define APB_SCHED_TIMEOUT_EN to enable the ACCESS-phase watchdog.
module apb_master_sched #(
    parameter int MASTERS        = 4,
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MASTERS-1:0]            req,
    input  logic [MASTERS-1:0]            req_write,
    input  logic [MASTERS*BUS_WIDTH-1:0]  req_addr,
    input  logic [MASTERS*DATA_WIDTH-1:0] req_wdata,
    output logic [MASTERS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic                          busy,
    output logic [$clog2(MASTERS)-1:0]    owner,
    output logic [BUS_WIDTH-1:0]          M_PADDR,
    output logic                          M_PWRITE,
    output logic                          M_PSEL,
    output logic                          M_PENABLE,
    output logic [DATA_WIDTH-1:0]         M_PWDATA,
    input  logic [DATA_WIDTH-1:0]         M_PRDATA,
    input  logic                          M_PREADY
);

    localparam int OW  = $clog2(MASTERS);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef APB_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [OW-1:0]   last_owner;
    logic [OW-1:0]   winner;
    logic            found;
    logic [TCW-1:0]  tcnt;
    logic            expire;
    logic            err_q;

    // First requester strictly after last_owner, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= MASTERS; i++) begin
            if (!found && req[(int'(last_owner) + i) % MASTERS]) begin
                found  = 1'b1;
                winner = OW'((int'(last_owner) + i) % MASTERS);
            end
        end
    end

    assign expire = TO_EN && (state == ACCESS) && !M_PREADY
                    && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        M_PSEL    = 1'b0;
        M_PENABLE = 1'b0;
        ack       = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                M_PSEL    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                M_PSEL    = 1'b1;
                M_PENABLE = 1'b1;
                if (M_PREADY || expire) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ack[owner] = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            M_PADDR    <= '0;
            M_PWRITE   <= 1'b0;
            M_PWDATA   <= '0;
            owner      <= '0;
            last_owner <= OW'(MASTERS - 1);
            rdata      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        M_PADDR  <= req_addr[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
                        M_PWRITE <= req_write[winner];
                        M_PWDATA <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        owner    <= winner;
                        rdata    <= '0;
                    end
                end
                ACCESS: begin
                    if (M_PREADY) begin
                        rdata <= M_PWRITE ? '0 : M_PRDATA;
                    end else if (expire) begin
                        rdata <= '0;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

    // Watchdog; constant-zero when the timeout feature is compiled out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == SETUP) begin
                tcnt <= '0;
            end else if (TO_EN && state == ACCESS && !M_PREADY) begin
                tcnt <= tcnt + 1'b1;
            end
            if (state == IDLE && found) begin
                err_q <= 1'b0;
            end else if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
